// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module : rsa_pkg
// Brief  : Command codes, FSM state encoding and default widths for the RSA
//          command responder.
// Rev    : 1.0
// ============================================================================
package rsa_pkg;

  localparam int RSA_DATA_W = 1024;
  localparam int RSA_CMD_W  = 32;

  localparam logic [RSA_CMD_W-1:0] CMD_WR_A    = 32'h0;
  localparam logic [RSA_CMD_W-1:0] CMD_WR_B    = 32'h1;
  localparam logic [RSA_CMD_W-1:0] CMD_WR_M    = 32'h2;
  localparam logic [RSA_CMD_W-1:0] CMD_EXP     = 32'h3;
  localparam logic [RSA_CMD_W-1:0] CMD_MONT    = 32'h4;
  localparam logic [RSA_CMD_W-1:0] CMD_WR_EMOD = 32'h5;
  localparam logic [RSA_CMD_W-1:0] CMD_WR_RMOD = 32'h6;
  localparam logic [RSA_CMD_W-1:0] CMD_WR_RSQ  = 32'h7;
  localparam logic [RSA_CMD_W-1:0] CMD_WR_X    = 32'h8;
  localparam logic [RSA_CMD_W-1:0] CMD_WR_E    = 32'h9;
  localparam logic [RSA_CMD_W-1:0] CMD_READ    = 32'hA;
  localparam logic [RSA_CMD_W-1:0] CMD_RST     = 32'hB;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_DATA   = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_TX_DATA   = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rsa_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module : rsa_cmd_responder
// Brief  : Decodes ARM commands, loads the operand bank, launches the
//          Montgomery / exponentiation cores and returns the result.
// Rev    : 1.0
// ============================================================================
module rsa_cmd_responder
  import rsa_pkg::*;
#(
  parameter int DATA_W = RSA_DATA_W,
  parameter int CMD_W  = RSA_CMD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  arm_to_fpga_cmd,
  input  logic              arm_to_fpga_cmd_valid,
  output logic              fpga_to_arm_done,
  input  logic              fpga_to_arm_done_read,
  input  logic              arm_to_fpga_data_valid,
  output logic              arm_to_fpga_data_ready,
  input  logic [DATA_W-1:0] arm_to_fpga_data,
  output logic              fpga_to_arm_data_valid,
  input  logic              fpga_to_arm_data_ready,
  output logic [DATA_W-1:0] fpga_to_arm_data,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] op_m,
  output logic [DATA_W-1:0] exp_x,
  output logic [DATA_W-1:0] exp_e,
  output logic [DATA_W-1:0] exp_mod,
  output logic [DATA_W-1:0] exp_rmod,
  output logic [DATA_W-1:0] exp_rsq,
  output logic              mont_start,
  output logic              mont_rst,
  input  logic              mont_done,
  input  logic [DATA_W-1:0] mont_result,
  output logic              exp_start,
  input  logic              exp_done,
  input  logic [DATA_W-1:0] exp_result
);

  state_t             state_q, state_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               mont_rst_q, mont_rst_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, op_m_q, op_m_d;
  logic [DATA_W-1:0]  exp_x_q, exp_x_d, exp_e_q, exp_e_d, exp_mod_q, exp_mod_d;
  logic [DATA_W-1:0]  exp_rmod_q, exp_rmod_d, exp_rsq_q, exp_rsq_d;
  logic [DATA_W-1:0]  result_q, result_d;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    mont_rst_d = 1'b0;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_m_d     = op_m_q;
    exp_x_d    = exp_x_q;
    exp_e_d    = exp_e_q;
    exp_mod_d  = exp_mod_q;
    exp_rmod_d = exp_rmod_q;
    exp_rsq_d  = exp_rsq_q;
    result_d   = result_q;

    case (state_q)
      ST_IDLE: begin
        if (arm_to_fpga_cmd_valid) begin
          cmd_d = arm_to_fpga_cmd;
          case (arm_to_fpga_cmd)
            CMD_WR_A, CMD_WR_B, CMD_WR_M, CMD_WR_EMOD, CMD_WR_RMOD,
            CMD_WR_RSQ, CMD_WR_X, CMD_WR_E: state_d = ST_RX_DATA;
            CMD_EXP, CMD_MONT:              state_d = ST_START;
            CMD_READ:                       state_d = ST_TX_DATA;
            CMD_RST: begin
              state_d    = ST_DONE;
              mont_rst_d = 1'b1;
            end
            default:                        state_d = ST_DONE;
          endcase
        end
      end
      ST_RX_DATA: begin
        // Leaving RX_DATA drops ready, so a held valid is consumed only once.
        if (arm_to_fpga_data_valid) begin
          state_d = ST_DONE;
          case (cmd_q)
            CMD_WR_A:    op_a_d     = arm_to_fpga_data;
            CMD_WR_B:    op_b_d     = arm_to_fpga_data;
            CMD_WR_M:    op_m_d     = arm_to_fpga_data;
            CMD_WR_EMOD: exp_mod_d  = arm_to_fpga_data;
            CMD_WR_RMOD: exp_rmod_d = arm_to_fpga_data;
            CMD_WR_RSQ:  exp_rsq_d  = arm_to_fpga_data;
            CMD_WR_X:    exp_x_d    = arm_to_fpga_data;
            CMD_WR_E:    exp_e_d    = arm_to_fpga_data;
            default:     ;
          endcase
        end
      end
      ST_START: state_d = ST_WAIT_CORE;
      ST_WAIT_CORE: begin
        if (cmd_q == CMD_MONT) begin
          if (mont_done) begin
            result_d = mont_result;
            state_d  = ST_DONE;
          end
        end else if (exp_done) begin
          result_d = exp_result;
          state_d  = ST_DONE;
        end
      end
      ST_TX_DATA: if (fpga_to_arm_data_ready) state_d = ST_DONE;
      ST_DONE:    if (fpga_to_arm_done_read)  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      mont_rst_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_m_q     <= '0;
      exp_x_q    <= '0;
      exp_e_q    <= '0;
      exp_mod_q  <= '0;
      exp_rmod_q <= '0;
      exp_rsq_q  <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      mont_rst_q <= mont_rst_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_m_q     <= op_m_d;
      exp_x_q    <= exp_x_d;
      exp_e_q    <= exp_e_d;
      exp_mod_q  <= exp_mod_d;
      exp_rmod_q <= exp_rmod_d;
      exp_rsq_q  <= exp_rsq_d;
      result_q   <= result_d;
    end
  end

  assign arm_to_fpga_data_ready = (state_q == ST_RX_DATA);
  assign fpga_to_arm_data_valid = (state_q == ST_TX_DATA);
  assign fpga_to_arm_done       = (state_q == ST_DONE);
  assign mont_start             = (state_q == ST_START) && (cmd_q == CMD_MONT);
  assign exp_start              = (state_q == ST_START) && (cmd_q == CMD_EXP);
  assign mont_rst               = mont_rst_q;
  assign fpga_to_arm_data       = result_q;
  assign op_a                   = op_a_q;
  assign op_b                   = op_b_q;
  assign op_m                   = op_m_q;
  assign exp_x                  = exp_x_q;
  assign exp_e                  = exp_e_q;
  assign exp_mod                = exp_mod_q;
  assign exp_rmod               = exp_rmod_q;
  assign exp_rsq                = exp_rsq_q;

endmodule
`default_nettype wire
